// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch path.
// This package holds the memory geometry, the HALT encoding, the fetch states and the buffer entry layout.
package cpu_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] DEFAULT_HALT_WORD = 8'h00;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small prefetch FIFO that holds {pc, instr} entries between fetch and decode.
// The head is read straight from storage, and a flush empties the buffer in a single cycle.
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  // Storage is cleared on reset so the head reads zero before the first fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory and feeds decode through a prefetch buffer.
// A redirect restarts fetch, and a HALT word stops fetch until the next redirect.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH     = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter bit                HALT_EN   = 1'b1,
  parameter logic [DATA_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic         push;
  logic         pop;
  logic         is_halt;
  logic         buf_empty;
  logic         buf_full;
  fetch_entry_t head;
  fetch_entry_t wr_entry;

  // A redirect blocks both push and pop so the flush sees a quiet buffer.
  assign pop      = instr_valid & instr_ready & ~redirect;
  assign push     = (state_q == RUN) & ~redirect & (~buf_full | pop);
  assign is_halt  = HALT_EN && (imem_data == HALT_WORD);
  assign wr_entry = '{pc: pc_q, instr: imem_data};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect) begin
      state_d = RUN;
      pc_d    = redirect_pc;
    end else if (push) begin
      if (is_halt) begin
        state_d = HALTED;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .wr_entry(wr_entry),
    .head    (head),
    .empty   (buf_empty),
    .full    (buf_full)
  );

  assign instr_valid = ~buf_empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign halted      = (state_q == HALTED);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural combinational instruction memory.
// It covers streaming, halt, backpressure, redirect, PC wrap-around and asynchronous reset.
module tb_fetch_unit;

  logic       clk;
  logic       rst;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] instr;
  logic [3:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect;
  logic [3:0] redirect_pc;
  logic       halted;
  logic [3:0] pc;

  logic [7:0] image [16];
  logic [7:0] defImg [10] = '{8'hA6, 8'hAF, 8'hB4, 8'hBD, 8'hF8, 8'hCB, 8'h9B, 8'hA7, 8'h7B, 8'h00};
  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halted     (halted),
    .pc         (pc)
  );

  assign imem_data = image[imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic loadDefault();
    for (int i = 0; i < 16; i++) begin
      image[i] = (i < 10) ? defImg[i] : 8'hEE;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    loadDefault();
    rst         = 1'b1;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 4'd0;
    #1;
    checkOutput("rst_valid", 8'(instr_valid), 8'h00);
    checkOutput("rst_halted", 8'(halted), 8'h00);
    checkOutput("rst_pc", 8'(pc), 8'h00);
    checkOutput("rst_instr", instr, 8'h00);
    checkOutput("rst_instr_pc", 8'(instr_pc), 8'h00);
    #2;
    rst = 1'b0;

    // Streaming run from reset up to the HALT word.
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput($sformatf("run_instr%0d", k), instr, defImg[k]);
      checkOutput($sformatf("run_ipc%0d", k), 8'(instr_pc), 8'(k));
      checkOutput($sformatf("run_valid%0d", k), 8'(instr_valid), 8'h01);
    end
    checkOutput("run_halted", 8'(halted), 8'h01);
    checkOutput("run_pc_hold", 8'(pc), 8'h09);
    tick();
    checkOutput("drain_valid", 8'(instr_valid), 8'h00);
    checkOutput("drain_halted", 8'(halted), 8'h01);
    checkOutput("drain_pc", 8'(pc), 8'h09);

    // Redirect out of HALTED.
    redirect    = 1'b1;
    redirect_pc = 4'd3;
    tick();
    redirect = 1'b0;
    checkOutput("rdh_halted", 8'(halted), 8'h00);
    checkOutput("rdh_valid", 8'(instr_valid), 8'h00);
    checkOutput("rdh_pc", 8'(pc), 8'h03);
    tick();
    checkOutput("rdh_instr", instr, 8'hBD);
    checkOutput("rdh_ipc", 8'(instr_pc), 8'h03);
    checkOutput("rdh_valid2", 8'(instr_valid), 8'h01);

    // Backpressure from reset.
    rst         = 1'b1;
    instr_ready = 1'b0;
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("bp_instr%0d", k), instr, 8'hA6);
      checkOutput($sformatf("bp_ipc%0d", k), 8'(instr_pc), 8'h00);
      checkOutput($sformatf("bp_valid%0d", k), 8'(instr_valid), 8'h01);
      checkOutput($sformatf("bp_pc%0d", k), 8'(pc), (k == 0) ? 8'h01 : 8'h02);
    end
    instr_ready = 1'b1;
    tick();
    checkOutput("rel_instr0", instr, 8'hAF);
    checkOutput("rel_ipc0", 8'(instr_pc), 8'h01);
    checkOutput("rel_pc0", 8'(pc), 8'h03);
    tick();
    checkOutput("rel_instr1", instr, 8'hB4);
    checkOutput("rel_ipc1", 8'(instr_pc), 8'h02);
    checkOutput("rel_valid1", 8'(instr_valid), 8'h01);

    // Redirect while B4 is at the head.
    redirect    = 1'b1;
    redirect_pc = 4'd6;
    tick();
    redirect = 1'b0;
    checkOutput("rd_valid", 8'(instr_valid), 8'h00);
    checkOutput("rd_pc", 8'(pc), 8'h06);
    for (int k = 6; k < 10; k++) begin
      tick();
      checkOutput($sformatf("rd_instr%0d", k), instr, defImg[k]);
      checkOutput($sformatf("rd_ipc%0d", k), 8'(instr_pc), 8'(k));
      checkOutput($sformatf("rd_valid%0d", k), 8'(instr_valid), 8'h01);
    end
    checkOutput("rd_halted", 8'(halted), 8'h01);
    tick();
    checkOutput("rd_drain_valid", 8'(instr_valid), 8'h00);

    // PC wrap from 15 to 0.
    image[15]   = 8'h11;
    image[0]    = 8'h22;
    image[1]    = 8'h00;
    redirect    = 1'b1;
    redirect_pc = 4'd15;
    tick();
    redirect = 1'b0;
    checkOutput("wr_valid", 8'(instr_valid), 8'h00);
    checkOutput("wr_halted", 8'(halted), 8'h00);
    checkOutput("wr_pc", 8'(pc), 8'h0F);
    tick();
    checkOutput("wr_instr15", instr, 8'h11);
    checkOutput("wr_ipc15", 8'(instr_pc), 8'h0F);
    checkOutput("wr_pc_wrap", 8'(pc), 8'h00);
    tick();
    checkOutput("wr_instr0", instr, 8'h22);
    checkOutput("wr_ipc0", 8'(instr_pc), 8'h00);
    instr_ready = 1'b0;
    tick();
    checkOutput("wr_halted2", 8'(halted), 8'h01);
    checkOutput("wr_pc_hold", 8'(pc), 8'h01);
    checkOutput("wr_head_stable", instr, 8'h22);
    checkOutput("wr_valid2", 8'(instr_valid), 8'h01);

    // Asynchronous reset with two entries buffered and fetch halted.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", 8'(instr_valid), 8'h00);
    checkOutput("ar_halted", 8'(halted), 8'h00);
    checkOutput("ar_pc", 8'(pc), 8'h00);
    checkOutput("ar_addr", 8'(imem_addr), 8'h00);
    loadDefault();
    rst         = 1'b0;
    instr_ready = 1'b1;
    tick();
    checkOutput("ar_instr", instr, 8'hA6);
    checkOutput("ar_ipc", 8'(instr_pc), 8'h00);
    checkOutput("ar_valid2", 8'(instr_valid), 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly downstream of instruction_memory, which has a 4-bit address, 8-bit data and a combinational read.
- Owns the program counter and drives the memory address.
- Captures each returned word with its PC into a small prefetch buffer.
- Presents instructions to decode/execute over a valid/ready handshake.
- Execute can redirect fetch (jump/branch). Fetch stops on a HALT word.

Parameters:
ADDR_W, 4, program counter / instruction memory address width
DATA_W, 8, instruction width
DEPTH, 2, prefetch buffer entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset
HALT_EN, 1, 1 = fetching the HALT_WORD stops fetch
HALT_WORD, 8'h00, instruction encoding treated as HALT

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_addr  out  ADDR_W  address to instruction_memory; equals pc
imem_data  in  DATA_W  combinational read data for imem_addr
instr  out  DATA_W  buffer-head instruction
instr_pc  out  ADDR_W  address the head instruction was fetched from
instr_valid  out  1  head entry valid
instr_ready  in  1  consumer accepts the head this cycle
redirect  in  1  execute requests a fetch restart (one-cycle pulse)
redirect_pc  in  ADDR_W  restart address
halted  out  1  fetch stopped on HALT
pc  out  ADDR_W  current fetch PC (debug/trace)

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: pc=RESET_PC, buffer empty, instr_valid=0, instr=0, instr_pc=0, halted=0, state=RUN. Assertion of rst mid-operation discards all buffered entries immediately.
- States: RUN and HALTED.
  - RUN->HALTED: a push of HALT_WORD while HALT_EN=1.
  - HALTED->RUN: redirect only.
  - rst: forces RUN.
- Address path: imem_addr = pc, combinational. The word is sampled in the same cycle as the address.
- push = (state==RUN) & !redirect & (!full | pop).
  - On push: write {pc, imem_data} to the tail.
  - If the pushed word is not a HALT, pc <= pc+1 modulo 2^ADDR_W (15 wraps to 0).
  - If the pushed word is a HALT (HALT_EN=1, imem_data==HALT_WORD): the HALT word is still pushed so the consumer sees it. pc holds at the HALT address and state becomes HALTED.
- pop = instr_valid & instr_ready & !redirect. The head advances.
- Simultaneous pop and push while full: legal, occupancy unchanged, no stall bubble.
- Empty buffer: instr_valid=0. instr/instr_pc hold their last value and are don't-care.
- redirect has priority over everything in that cycle. No push and no pop are performed.
  - Next cycle: buffer empty, pc=redirect_pc, halted=0, state=RUN.
  - instr_valid is 0 in the cycle after redirect. The first redirected instruction is valid one cycle later.
- Latency: word at address A is pushed in the cycle pc==A. instr_valid for it is visible after the next rising edge, i.e. 1-cycle fetch-to-valid latency.
- Throughput: 1 instr/cycle sustained with instr_ready held high.
- Backpressure: with instr_ready=0, fetch continues until DEPTH entries are held, then pc stalls. Head outputs are stable while valid & !ready.
- HALTED: no pushes. Remaining buffered entries still drain normally. halted=1 from the edge that pushed the HALT word.
- Outputs are registered or come straight from buffer storage; there are no combinational paths from instr_ready to instr/instr_valid. imem_addr depends only on the pc register.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W and DATA_W constants
  - HALT_WORD constant
  - fetch state typedef (RUN, HALTED)
  - fetch entry struct typedef {pc, instr}
- One sub-module: fetch_buffer, a DEPTH-entry synchronous FIFO.
  - Inputs: push, pop, flush, async rst.
  - Outputs: head, empty, full.
  - Stores {instr_pc, instr}.
- fetch_unit holds the pc, the state machine and the push/pop/redirect priority.

Test Plan:
- Default image (A6 AF B4 BD F8 CB 9B A7 7B 00 ...), instr_ready=1, from reset:
  - instr sequence A6,AF,B4,BD,F8,CB,9B,A7,7B,00 with instr_pc 0..9, one per cycle.
  - halted=1 when 00 is pushed; pc stays 9; instr_valid=0 after 00 is consumed.
- Backpressure: hold instr_ready=0 for 5 cycles after reset:
  - Buffer fills to 2 (A6, AF); pc stalls at 2; instr=A6 stable.
  - Release instr_ready: B4 follows AF with no gap.
- Redirect: pulse redirect with redirect_pc=6 while instr=B4 valid:
  - Next cycle instr_valid=0.
  - Then 9B (pc 6), A7, 7B, 00 follow, then halted.
- Redirect out of HALTED: after halt at pc 9, redirect to 3:
  - halted deasserts; instr BD with instr_pc 3 is valid 2 cycles after the pulse.
- Wrap-around: image with address 15 = 8'h11 and addresses 0..1 = 8'h22, 8'h00; redirect to 15:
  - instr 11 (pc 15), 22 (pc 0), 00 (pc 1); halted=1.
- Async reset mid-stream: assert rst between clock edges while 2 entries are buffered:
  - instr_valid and halted drop immediately; pc=0.
  - After release, A6 is valid one edge later.
